branch_redirect: RTL

BRANCH_REDIRECT -- requirements
Module: branch_redirect

---
 rtl/branch_redirect.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - IF/ID register with branch/jump resolution, fetch redirect and wrong-path squash
module branch_redirect #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instruction,
  input  logic [31:0] if_pc,
  input  logic        if_halt,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        npc_control,
  output logic [31:0] branch_pc,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, SQUASH, HALT} state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [2:0]  FLUSH_CNT = 3'(FLUSH_DEPTH);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        npc_nxt, idv_nxt, halted_nxt;
  logic [31:0] bpc_nxt, idi_nxt, idpc_nxt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_b, imm_j, imm_i, target;
  logic        taken, eval, redirect, misalign;

  assign opcode = id_instruction[6:0];
  assign funct3 = id_instruction[14:12];
  assign imm_b  = {{20{id_instruction[31]}}, id_instruction[7], id_instruction[30:25],
                   id_instruction[11:8], 1'b0};
  assign imm_j  = {{12{id_instruction[31]}}, id_instruction[19:12], id_instruction[20],
                   id_instruction[30:21], 1'b0};
  assign imm_i  = {{20{id_instruction[31]}}, id_instruction[31:20]};

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (opcode)
      OP_BRANCH: begin
        target = id_pc + imm_b;
        case (funct3)
          3'b000:  taken = (rs1_data == rs2_data);
          3'b001:  taken = (rs1_data != rs2_data);
          3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  taken = (rs1_data <  rs2_data);
          3'b111:  taken = (rs1_data >= rs2_data);
          default: taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        taken  = 1'b1;
        target = id_pc + imm_j;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = (rs1_data + imm_i) & ~32'd1;
      end
      default: taken = 1'b0;
    endcase
  end

  // Only a correct-path instruction in RUN may steer fetch; a word-misaligned target halts instead
  assign eval     = (state == RUN) && id_valid;
  assign redirect = eval && taken && !target[1];
  assign misalign = eval && taken &&  target[1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    npc_nxt    = 1'b0;
    bpc_nxt    = branch_pc;
    idi_nxt    = if_instruction;
    idpc_nxt   = if_pc;
    idv_nxt    = 1'b0;
    halted_nxt = halted;
    case (state)
      RUN: begin
        if (redirect) begin
          npc_nxt   = 1'b1;
          bpc_nxt   = target;
          cnt_nxt   = FLUSH_CNT;
          state_nxt = SQUASH;
        end else if (misalign || if_halt) begin
          halted_nxt = 1'b1;
          state_nxt  = HALT;
        end else begin
          idv_nxt = 1'b1;
        end
      end
      SQUASH: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
          idv_nxt   = 1'b1;
        end
      end
      HALT: begin
        idi_nxt  = id_instruction;
        idpc_nxt = id_pc;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      cnt            <= '0;
      npc_control    <= 1'b0;
      branch_pc      <= '0;
      id_instruction <= NOP;
      id_pc          <= '0;
      id_valid       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      npc_control    <= npc_nxt;
      branch_pc      <= bpc_nxt;
      id_instruction <= idi_nxt;
      id_pc          <= idpc_nxt;
      id_valid       <= idv_nxt;
      halted         <= halted_nxt;
    end
  end

endmodule
